// File: rtl/irq_latch.sv
// irq_latch: edge-latching interrupt front end with a 3-state CPU handshake.
// Optional mask register behind macro IRQ_LATCH_MASK_EN.
//
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   req_n[7:0] - active-low request lines, bit 7 highest priority
//   mask_we    - mask write strobe (IRQ_LATCH_MASK_EN only)
//   mask_din   - mask write data   (IRQ_LATCH_MASK_EN only)
//   idx[2:0]   - index returned by the external priority encoder
//   ack        - CPU acknowledge level
//   pend_n     - active-low pending vector to the encoder
//   en_n       - active-low encoder enable
//   irq        - registered interrupt request
//   irq_vec    - registered source index, stable while irq=1
module irq_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_n,
`ifdef IRQ_LATCH_MASK_EN
    input  logic       mask_we,
    input  logic [7:0] mask_din,
`endif
    input  logic [2:0] idx,
    input  logic       ack,
    output logic [7:0] pend_n,
    output logic       en_n,
    output logic       irq,
    output logic [2:0] irq_vec
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RELEASE
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [7:0] req_q;
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] fall;
    logic [7:0] clr;
    logic [7:0] live;
    logic       irq_d;
    logic [2:0] vec_d;

`ifdef IRQ_LATCH_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= 8'hFF;
        end else if (mask_we) begin
            mask <= mask_din;
        end
    end
`else
    assign mask = 8'hFF;
`endif

    // Masked bits keep latching; they are only hidden from the encoder.
    assign fall   = req_q & ~req_n;
    assign live   = pend & mask;
    assign pend_n = ~live;
    assign en_n   = ~|live;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 8'hFF;
            pend    <= 8'h00;
            state   <= IDLE;
            irq     <= 1'b0;
            irq_vec <= 3'd0;
        end else begin
            req_q   <= req_n;
            // A new edge on the bit being cleared wins.
            pend    <= (pend & ~clr) | fall;
            state   <= state_d;
            irq     <= irq_d;
            irq_vec <= vec_d;
        end
    end

    always_comb begin
        state_d = state;
        irq_d   = irq;
        vec_d   = irq_vec;
        clr     = 8'h00;
        unique case (state)
            IDLE: begin
                if (!en_n) begin
                    vec_d   = idx;
                    irq_d   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    clr     = 8'h01 << irq_vec;
                    irq_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_latch.sv
// tb_irq_latch: directed scenarios plus randomized run against a
// behavioural model of the interrupt latch and handshake.
module tb_irq_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic       ack;
    logic [7:0] req_n;
    logic [2:0] idx;
    logic [7:0] pend_n;
    logic       en_n;
    logic       irq;
    logic [2:0] irq_vec;
`ifdef IRQ_LATCH_MASK_EN
    logic       mask_we;
    logic [7:0] mask_din;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    irq_latch dut (
        .clk     (clk),
        .rst     (rst),
        .req_n   (req_n),
`ifdef IRQ_LATCH_MASK_EN
        .mask_we (mask_we),
        .mask_din(mask_din),
`endif
        .idx     (idx),
        .ack     (ack),
        .pend_n  (pend_n),
        .en_n    (en_n),
        .irq     (irq),
        .irq_vec (irq_vec)
    );

    // External 8-to-3 priority encoder.
    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = i[2:0];
        end
        return r;
    endfunction

    assign idx = enc(~pend_n);

    // Reference model: per-source pending flags, served source, phase.
    bit m_pend[8];
    bit m_prev[8];
    bit m_mask[8];
    bit m_irq;
    int m_vec;
    int m_phase;
    int m_top;
    bit m_fell[8];

    function automatic logic [7:0] m_pend_n();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = !(m_pend[i] && m_mask[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0;
                m_prev[i] = 1;
                m_mask[i] = 1;
            end
            m_irq   = 0;
            m_vec   = 0;
            m_phase = 0;
        end else begin
            for (int i = 0; i < 8; i++) m_fell[i] = m_prev[i] && !req_n[i];
            m_top = -1;
            for (int i = 7; i >= 0; i--) begin
                if (m_top < 0 && m_pend[i] && m_mask[i]) m_top = i;
            end
            if (m_phase == 0) begin
                if (m_top >= 0) begin
                    m_vec   = m_top;
                    m_irq   = 1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (ack) begin
                    m_pend[m_vec] = 0;
                    m_irq         = 0;
                    m_phase       = 2;
                end
            end else begin
                if (!ack) m_phase = 0;
            end
            for (int i = 0; i < 8; i++) begin
                if (m_fell[i]) m_pend[i] = 1;
                m_prev[i] = req_n[i];
            end
`ifdef IRQ_LATCH_MASK_EN
            if (mask_we) begin
                for (int i = 0; i < 8; i++) m_mask[i] = mask_din[i];
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (pend_n !== 8'hFF) begin
            fails++;
            $display("FAIL reset_pend_n got %h want ff", pend_n);
        end
        tests++;
        if (en_n !== 1'b1 || irq !== 1'b0 || irq_vec !== 3'd0) begin
            fails++;
            $display("FAIL reset_outs got en_n=%b irq=%b vec=%0d want 1 0 0",
                     en_n, irq, irq_vec);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        ack = 1'b1;
        tick();
        tests++;
        if (irq !== 1'b0 || en_n !== 1'b1) begin
            fails++;
            $display("FAIL ack_idle got irq=%b en_n=%b want 0 1", irq, en_n);
        end
        ack   = 1'b0;
        req_n = 8'hF7;
        tick();
        tests++;
        if (pend_n !== 8'hF7 || irq !== 1'b0) begin
            fails++;
            $display("FAIL single_pend got pend_n=%h irq=%b want f7 0",
                     pend_n, irq);
        end
        tick();
        tests++;
        if (irq !== 1'b1 || irq_vec !== 3'd3) begin
            fails++;
            $display("FAIL single_irq got irq=%b vec=%0d want 1 3", irq, irq_vec);
        end
        ack = 1'b1;
        tick();
        tests++;
        if (irq !== 1'b0 || pend_n !== 8'hFF) begin
            fails++;
            $display("FAIL single_ack got irq=%b pend_n=%h want 0 ff",
                     irq, pend_n);
        end
        ack = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (irq !== 1'b0 || pend_n !== 8'hFF) begin
            fails++;
            $display("FAIL level_hold got irq=%b pend_n=%h want 0 ff",
                     irq, pend_n);
        end
        req_n = 8'hFF;
        tick();
    endtask

    task automatic test_priority();
        req_n = 8'h7E;
        tick();
        tick();
        tests++;
        if (irq !== 1'b1 || irq_vec !== 3'd7) begin
            fails++;
            $display("FAIL prio_first got irq=%b vec=%0d want 1 7", irq, irq_vec);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();
        tests++;
        if (irq !== 1'b1 || irq_vec !== 3'd0) begin
            fails++;
            $display("FAIL prio_second got irq=%b vec=%0d want 1 0", irq, irq_vec);
        end
        ack = 1'b1;
        tick();
        tests++;
        if (en_n !== 1'b1) begin
            fails++;
            $display("FAIL prio_drain got en_n=%b want 1", en_n);
        end
        ack   = 1'b0;
        req_n = 8'hFF;
        tick();
    endtask

    task automatic test_late_higher();
        req_n = 8'hFB;
        tick();
        tick();
        tests++;
        if (irq !== 1'b1 || irq_vec !== 3'd2) begin
            fails++;
            $display("FAIL late_first got irq=%b vec=%0d want 1 2", irq, irq_vec);
        end
        req_n = 8'hBB;
        tick();
        tick();
        tests++;
        if (irq !== 1'b1 || irq_vec !== 3'd2 || pend_n !== 8'hBB) begin
            fails++;
            $display("FAIL late_hold got irq=%b vec=%0d pend_n=%h want 1 2 bb",
                     irq, irq_vec, pend_n);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();
        tests++;
        if (irq !== 1'b1 || irq_vec !== 3'd6) begin
            fails++;
            $display("FAIL late_second got irq=%b vec=%0d want 1 6", irq, irq_vec);
        end
        ack = 1'b1;
        tick();
        ack   = 1'b0;
        req_n = 8'hFF;
        tick();
    endtask

    task automatic test_collision();
        req_n = 8'hEF;
        tick();
        tick();
        req_n = 8'hFF;
        tick();
        req_n = 8'hEF;
        ack   = 1'b1;
        tick();
        tests++;
        if (pend_n[4] !== 1'b0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL collide_keep got pend_n=%h irq=%b want bit4=0 irq=0",
                     pend_n, irq);
        end
        ack = 1'b0;
        tick();
        tick();
        tests++;
        if (irq !== 1'b1 || irq_vec !== 3'd4) begin
            fails++;
            $display("FAIL collide_reissue got irq=%b vec=%0d want 1 4",
                     irq, irq_vec);
        end
        ack = 1'b1;
        tick();
        ack   = 1'b0;
        req_n = 8'hFF;
        tick();
    endtask

    task automatic test_rst_mid();
        req_n = 8'hFD;
        tick();
        tick();
        req_n = 8'hF5;
        rst   = 1'b1;
        tick();
        tests++;
        if (pend_n !== 8'hFF || irq !== 1'b0 || irq_vec !== 3'd0) begin
            fails++;
            $display("FAIL rst_mid got pend_n=%h irq=%b vec=%0d want ff 0 0",
                     pend_n, irq, irq_vec);
        end
        rst   = 1'b0;
        req_n = 8'hFF;
        tick();
        tick();
        tests++;
        if (en_n !== 1'b1 || irq !== 1'b0) begin
            fails++;
            $display("FAIL rst_edge_lost got en_n=%b irq=%b want 1 0", en_n, irq);
        end
    endtask

`ifdef IRQ_LATCH_MASK_EN
    task automatic test_mask();
        mask_we  = 1'b1;
        mask_din = 8'hDF;
        tick();
        mask_we = 1'b0;
        req_n   = 8'hDF;
        tick();
        tick();
        tests++;
        if (irq !== 1'b0 || pend_n !== 8'hFF) begin
            fails++;
            $display("FAIL mask_hide got irq=%b pend_n=%h want 0 ff", irq, pend_n);
        end
        mask_we  = 1'b1;
        mask_din = 8'hFF;
        tick();
        mask_we = 1'b0;
        tick();
        tests++;
        if (irq !== 1'b1 || irq_vec !== 3'd5) begin
            fails++;
            $display("FAIL mask_unmask got irq=%b vec=%0d want 1 5", irq, irq_vec);
        end
        ack = 1'b1;
        tick();
        ack   = 1'b0;
        req_n = 8'hFF;
        tick();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) req_n[b] = ~req_n[b];
            end
            ack = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 79) == 0);
`ifdef IRQ_LATCH_MASK_EN
            mask_we  = ($urandom_range(0, 15) == 0);
            mask_din = 8'($urandom);
`endif
            tick();
            tests++;
            if (pend_n !== m_pend_n() || en_n !== (m_pend_n() == 8'hFF)) begin
                fails++;
                $display("FAIL rand_pend n=%0d got pend_n=%h en_n=%b want %h",
                         n, pend_n, en_n, m_pend_n());
            end
            tests++;
            if (irq !== m_irq || (m_irq && irq_vec !== 3'(m_vec))) begin
                fails++;
                $display("FAIL rand_irq n=%0d got irq=%b vec=%0d want %b %0d",
                         n, irq, irq_vec, m_irq, m_vec);
            end
        end
        rst = 1'b0;
        ack = 1'b0;
`ifdef IRQ_LATCH_MASK_EN
        mask_we = 1'b0;
`endif
    endtask

    initial begin
        rst   = 1'b1;
        ack   = 1'b0;
        req_n = 8'hFF;
`ifdef IRQ_LATCH_MASK_EN
        mask_we  = 1'b0;
        mask_din = 8'hFF;
`endif
        test_reset();
        test_single();
        test_priority();
        test_late_higher();
        test_collision();
        test_rst_mid();
`ifdef IRQ_LATCH_MASK_EN
        test_mask();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
